// File: rtl/heater_actuator_driver.sv
// -----------------------------------------------------------------------------
// heater_actuator_driver
//
// Purpose:
//   Turns the 1-bit heat request from the heating controller into a relay
//   drive for the physical heater. It adds the following protections:
//     - anti-short-cycle: a minimum on-time and a minimum off-time,
//     - relay supervision: relay feedback is compared with the drive, and a
//       persistent disagreement latches a fault until it is acknowledged,
//     - status: the current state and a count of completed normal ON cycles
//       are reported to the home-automation logic.
//
// Ports:
//   clk_i           system clock; all logic runs on the rising edge
//   reset_i         synchronous, active-high reset (overrides all inputs)
//   heat_req_i      heat request from the heating controller
//   heater_fb_i     relay feedback, 1 = heater energised
//   fault_clr_i     fault acknowledge, sampled as a level
//   heater_on_o     relay drive, high only in RUN
//   heater_state_o  0 = IDLE, 1 = RUN, 2 = LOCKOUT, 3 = FAULT
//   fault_o         high while in FAULT
//   cycle_count_o   completed normal ON cycles, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module heater_actuator_driver #(
  parameter int unsigned MIN_ON_CYCLES  = 8,
  parameter int unsigned MIN_OFF_CYCLES = 6,
  parameter int unsigned FB_TIMEOUT     = 4,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        heat_req_i,
  input  logic        heater_fb_i,
  input  logic        fault_clr_i,
  output logic        heater_on_o,
  output logic [1:0]  heater_state_o,
  output logic        fault_o,
  output logic [15:0] cycle_count_o
);

  // ---------------------------------------------------------------------------
  // State encoding. The numeric values are visible on heater_state_o.
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_LOCKOUT = 2'd2;
  localparam logic [1:0] ST_FAULT   = 2'd3;

  // Terminal values for the timers, pre-sized to the counter width so that the
  // comparisons below are all made at CNT_W bits.
  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(MIN_OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(MIN_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] FB_LAST   = CNT_W'(FB_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [15:0]      CYCLE_MAX = 16'hFFFF;

  // ---------------------------------------------------------------------------
  // Registers and their next-state values
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q,       state_d;
  logic [CNT_W-1:0] timer_q,       timer_d;
  logic [CNT_W-1:0] mismatch_q,    mismatch_d;
  logic [15:0]      cycle_count_q, cycle_count_d;

  // ---------------------------------------------------------------------------
  // Internal decode
  // ---------------------------------------------------------------------------
  logic drive_on;       // relay drive decoded from the registered state
  logic fb_mismatch;    // feedback disagrees with the drive this cycle
  logic fault_trip;     // mismatch persisted for FB_TIMEOUT cycles
  logic state_change;   // state_d differs from state_q
  logic run_complete;   // normal end of an ON cycle

  // The drive depends only on the registered state. A request therefore takes
  // effect one edge after it is sampled, and the relay never sees a glitch
  // from the combinational inputs.
  assign drive_on    = (state_q == ST_RUN);
  assign fb_mismatch = (heater_fb_i != drive_on);

  // Supervision runs in every state except FAULT. The trip fires on the edge
  // that would otherwise record the FB_TIMEOUT-th consecutive mismatch.
  assign fault_trip = (state_q != ST_FAULT) && fb_mismatch
                      && (mismatch_q == FB_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before the case. Without
    // the default, a missing branch would infer a latch.
    state_d      = state_q;
    run_complete = 1'b0;

    if (fault_trip) begin
      // A fault trip overrides any normal transition on the same edge. That
      // includes the end of a RUN cycle, so a tripped cycle is not counted.
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_LOCKOUT: begin
          // heat_req is ignored in this state. The exit happens after exactly
          // MIN_OFF_CYCLES cycles in LOCKOUT.
          if (timer_q == OFF_LAST) begin
            state_d = ST_IDLE;
          end
        end

        ST_IDLE: begin
          if (heat_req_i) begin
            state_d = ST_RUN;
          end
        end

        ST_RUN: begin
          // If heat_req drops before the minimum on-time, the drop is held off
          // until the minimum is met. Comparing with >= keeps the exit valid
          // after the timer has saturated.
          if (!heat_req_i && (timer_q >= ON_LAST)) begin
            state_d      = ST_LOCKOUT;
            run_complete = 1'b1;
          end
        end

        ST_FAULT: begin
          // The fault is acknowledged only while nothing is requesting heat.
          // The exit goes through LOCKOUT, so the relay still gets its full
          // off-time.
          if (fault_clr_i && !heat_req_i) begin
            state_d = ST_LOCKOUT;
          end
        end

        default: begin
          state_d = ST_LOCKOUT;
        end
      endcase
    end
  end

  assign state_change = (state_d != state_q);

  // Timer: restarts at every state change. Otherwise it counts up and
  // saturates, so it cannot wrap around during a long RUN or FAULT.
  always_comb begin
    timer_d = timer_q;
    if (state_change) begin
      timer_d = '0;
    end else if (timer_q != CNT_MAX) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Mismatch counter: counts only consecutive disagreeing cycles. It is held
  // at zero in FAULT and restarts at every state change, so the short
  // feedback lag right after a drive transition cannot add up across states.
  always_comb begin
    mismatch_d = '0;
    if (!state_change && (state_q != ST_FAULT) && fb_mismatch
        && (mismatch_q != CNT_MAX)) begin
      mismatch_d = mismatch_q + 1'b1;
    end
  end

  // Count of completed ON cycles. It saturates instead of wrapping, so the
  // status side never sees the count go backwards.
  always_comb begin
    cycle_count_d = cycle_count_q;
    if (run_complete && (cycle_count_q != CYCLE_MAX)) begin
      cycle_count_d = cycle_count_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples its pre-edge inputs no matter how the
    // statements are ordered.
    if (reset_i) begin
      // Power-up starts in LOCKOUT. A relay that was just de-energised by the
      // reset therefore still gets its full off-time.
      state_q       <= ST_LOCKOUT;
      timer_q       <= '0;
      mismatch_q    <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      mismatch_q    <= mismatch_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registers
  // ---------------------------------------------------------------------------
  assign heater_on_o    = drive_on;
  assign fault_o        = (state_q == ST_FAULT);
  assign heater_state_o = state_q;
  assign cycle_count_o  = cycle_count_q;

endmodule

// File: tb/tb_heater_actuator_driver.sv
// -----------------------------------------------------------------------------
// tb_heater_actuator_driver
//
// Directed bench for heater_actuator_driver, using the default parameters.
// The relay feedback comes from a small relay model. Its source is one of:
//   - the drive delayed by one cycle (a healthy relay),
//   - stuck at 0 (a relay that fails to close),
//   - stuck at 1 (a welded relay).
// Inputs change, and outputs are sampled, 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_heater_actuator_driver;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] LOCKOUT = 2'd2;
  localparam logic [1:0] FAULT   = 2'd3;

  typedef enum logic [1:0] {FB_LAG, FB_ZERO, FB_ONE} fb_mode_e;

  logic        clk;
  logic        reset;
  logic        heat_req;
  logic        heater_fb;
  logic        fault_clr;
  logic        heater_on;
  logic [1:0]  heater_state;
  logic        fault;
  logic [15:0] cycle_count;

  fb_mode_e fb_mode;
  logic     fb_lag;

  int total;
  int bad;

  heater_actuator_driver dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .heat_req_i     (heat_req),
    .heater_fb_i    (heater_fb),
    .fault_clr_i    (fault_clr),
    .heater_on_o    (heater_on),
    .heater_state_o (heater_state),
    .fault_o        (fault),
    .cycle_count_o  (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Relay model: a healthy relay follows the drive with one cycle of lag.
  initial fb_lag = 1'b0;
  always @(posedge clk) fb_lag <= heater_on;

  always_comb begin
    case (fb_mode)
      FB_ZERO: heater_fb = 1'b0;
      FB_ONE:  heater_fb = 1'b1;
      default: heater_fb = fb_lag;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares all four outputs against the expected state and count. The
  // expected drive and fault flag are derived from the expected state.
  task automatic chk_out(input string tag, input logic [1:0] st,
                         input logic [15:0] cnt);
    check({tag, ".state"}, 16'(heater_state), 16'(st));
    check({tag, ".on"},    16'(heater_on),    16'(st == RUN));
    check({tag, ".fault"}, 16'(fault),        16'(st == FAULT));
    check({tag, ".count"}, cycle_count,       cnt);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    heat_req  = 1'b0;
    fault_clr = 1'b0;
    fb_mode   = FB_LAG;
    tick();
    tick();
    chk_out("reset", LOCKOUT, 16'd0);

    // Power-up lockout with heat_req held from reset release.
    reset    = 1'b0;
    heat_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("pwr_lock%0d", i), LOCKOUT, 16'd0);
    end
    tick();
    chk_out("pwr_idle", IDLE, 16'd0);
    tick();
    chk_out("pwr_run", RUN, 16'd0);
    // Keep the request up. The one-cycle feedback lag must not trip a fault.
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out($sformatf("pwr_hold%0d", i), RUN, 16'd0);
    end
    // The RUN timer is now 6. Drop the request: one more edge in RUN, then
    // the cycle ends.
    heat_req = 1'b0;
    tick();
    chk_out("pwr_min_on", RUN, 16'd0);
    tick();
    chk_out("pwr_end", LOCKOUT, 16'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("pwr_off%0d", i), LOCKOUT, 16'd1);
    end
    tick();
    chk_out("pwr_off_done", IDLE, 16'd1);

    // Short request: a 1-cycle pulse still gives exactly 8 cycles of drive.
    heat_req = 1'b1;
    tick();
    chk_out("short_run0", RUN, 16'd1);
    heat_req = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk_out($sformatf("short_run%0d", i), RUN, 16'd1);
    end
    tick();
    chk_out("short_lock0", LOCKOUT, 16'd2);

    // Request raised and dropped during lockout: it is ignored.
    heat_req = 1'b1;
    tick();
    chk_out("lkreq1", LOCKOUT, 16'd2);
    tick();
    chk_out("lkreq2", LOCKOUT, 16'd2);
    heat_req = 1'b0;
    for (int i = 3; i < 6; i++) begin
      tick();
      chk_out($sformatf("lkreq%0d", i), LOCKOUT, 16'd2);
    end
    tick();
    chk_out("lkreq_idle", IDLE, 16'd2);
    heat_req = 1'b1;
    tick();
    chk_out("lkreq_run", RUN, 16'd2);
    heat_req = 1'b0;
    for (int i = 1; i < 8; i++) tick();
    tick();
    chk_out("lkreq_end", LOCKOUT, 16'd3);
    for (int i = 0; i < 6; i++) tick();
    chk_out("lkreq_back_idle", IDLE, 16'd3);

    // Relay fails to close: the drive lasts 4 cycles, then FAULT, and the
    // cycle count is unchanged.
    fb_mode  = FB_ZERO;
    heat_req = 1'b1;
    tick();
    chk_out("noclose_run0", RUN, 16'd3);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_out($sformatf("noclose_run%0d", i), RUN, 16'd3);
    end
    tick();
    chk_out("noclose_fault", FAULT, 16'd3);
    // Acknowledge without a request, then ride out the full off-time.
    heat_req  = 1'b0;
    fault_clr = 1'b1;
    tick();
    chk_out("noclose_clr", LOCKOUT, 16'd3);
    fault_clr = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_out("noclose_lock_end", LOCKOUT, 16'd3);
    tick();
    chk_out("noclose_idle", IDLE, 16'd3);

    // Welded relay in IDLE: FAULT after 4 mismatching cycles.
    fb_mode = FB_ONE;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("weld_idle%0d", i), IDLE, 16'd3);
    end
    tick();
    chk_out("weld_fault", FAULT, 16'd3);
    // fault_clr with heat_req high is ignored.
    fault_clr = 1'b1;
    heat_req  = 1'b1;
    tick();
    chk_out("weld_clr_req1", FAULT, 16'd3);
    tick();
    chk_out("weld_clr_req2", FAULT, 16'd3);
    // fault_clr with heat_req low clears into a full lockout.
    heat_req = 1'b0;
    fb_mode  = FB_LAG;
    tick();
    chk_out("weld_clr", LOCKOUT, 16'd3);
    // fault_clr is still high here. Outside FAULT it has no effect.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("weld_lock%0d", i), LOCKOUT, 16'd3);
    end
    tick();
    chk_out("weld_idle", IDLE, 16'd3);
    fault_clr = 1'b0;

    // Reset mid-RUN at RUN timer == 3.
    heat_req = 1'b1;
    tick();
    chk_out("rst_run0", RUN, 16'd3);
    for (int i = 0; i < 3; i++) tick();
    chk_out("rst_run3", RUN, 16'd3);
    reset = 1'b1;
    tick();
    chk_out("rst_mid_run", LOCKOUT, 16'd0);
    reset    = 1'b0;
    heat_req = 1'b0;
    tick();
    chk_out("rst_after", LOCKOUT, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
